arbiter_rr_reg: RTL and testbench

Registered N-way valid/ready arbiter that merges N request streams into one output stream. It is the parametrised successor of the combinational fixed-priority arbiter. It adds a selectable round-robin or fixed-priority policy, a one-entry output register that breaks the out_valid/out_data timing path, and an index tag reporting which input was granted. It sits wherever several engines or queues share one downstream consumer.

---
 rtl/arbiter_rr_reg.sv | 54 +++++
 tb/tb_arbiter_rr_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_reg.sv
// arbiter_rr_reg: registered N-way valid/ready arbiter, round-robin or fixed priority, with grant index tag
module arbiter_rr_reg #(
    parameter int DWIDTH = 8,
    parameter int N = 2,
    parameter int RR = 1,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               in_valid,
    input  logic [N-1:0][DWIDTH-1:0]   in_data,
    output logic [N-1:0]               in_ready,
    output logic                       out_valid,
    output logic [DWIDTH-1:0]          out_data,
    output logic [SELW-1:0]            out_sel,
    input  logic                       out_ready
);
    logic [SELW-1:0]   ptr_q, ptr_d, out_sel_q, out_sel_d, gnt;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d, load, any;
    int                idx;
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            idx = (idx >= N) ? idx - N : idx;
            gnt = in_valid[idx] ? SELW'(idx) : gnt;
        end
        any         = |in_valid;
        load        = !out_valid_q || out_ready;
        in_ready    = (load && any && !rst) ? N'(1) << gnt : '0;
        out_valid_d = load ? any : out_valid_q;
        out_data_d  = (load && any) ? in_data[gnt] : out_data_q;
        out_sel_d   = (load && any) ? gnt : out_sel_q;
        ptr_d       = (RR != 0 && load && any) ? ((int'(gnt) == N - 1) ? '0 : gnt + 1'b1) : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_arbiter_rr_reg.sv
// tb_arbiter_rr_reg: scoreboard bench for arbiter_rr_reg across RR/fixed, N=4/2/1 instances
module tb_arbiter_rr_reg;
    logic            clk = 1'b0, rst = 1'b1, rdy = 1'b1;
    logic [3:0]      vin = '0;
    logic [3:0][7:0] vd = '0;
    logic [3:0]      rr_ir, fp_ir;
    logic [1:0]      n2_ir, rr_os, fp_os;
    logic [0:0]      n1_ir, n2_os, n1_os;
    logic            rr_ov, fp_ov, n2_ov, n1_ov, mv;
    logic [7:0]      rr_od, fp_od, n2_od, n1_od;
    int              ms, md;
    typedef struct {int sel; int data;} beat_t;
    beat_t           q[$];
    beat_t           b;
    int              act = -1, n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    arbiter_rr_reg #(.DWIDTH(8), .N(4), .RR(1)) u_rr4 (
        .clk(clk), .rst(rst), .in_valid(vin), .in_data(vd), .in_ready(rr_ir),
        .out_valid(rr_ov), .out_data(rr_od), .out_sel(rr_os), .out_ready(rdy));
    arbiter_rr_reg #(.DWIDTH(8), .N(4), .RR(0)) u_fp4 (
        .clk(clk), .rst(rst), .in_valid(vin), .in_data(vd), .in_ready(fp_ir),
        .out_valid(fp_ov), .out_data(fp_od), .out_sel(fp_os), .out_ready(rdy));
    arbiter_rr_reg #(.DWIDTH(8), .N(2), .RR(1)) u_n2 (
        .clk(clk), .rst(rst), .in_valid(vin[1:0]), .in_data(vd[1:0]), .in_ready(n2_ir),
        .out_valid(n2_ov), .out_data(n2_od), .out_sel(n2_os), .out_ready(rdy));
    arbiter_rr_reg #(.DWIDTH(8), .N(1), .RR(1)) u_n1 (
        .clk(clk), .rst(rst), .in_valid(vin[0:0]), .in_data(vd[0:0]), .in_ready(n1_ir),
        .out_valid(n1_ov), .out_data(n1_od), .out_sel(n1_os), .out_ready(rdy));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int who);
        act = -1;
        rst = 1'b1;
        vin = '0;
        nxt();
        rst = 1'b0;
        act = who;
    endtask

    always_comb begin
        mv = (act == 0) ? rr_ov : (act == 1) ? fp_ov : (act == 2) ? n2_ov : (act == 3) ? n1_ov : 1'b0;
        ms = (act == 0) ? int'(rr_os) : (act == 1) ? int'(fp_os) : (act == 2) ? int'(n2_os) : int'(n1_os);
        md = (act == 0) ? int'(rr_od) : (act == 1) ? int'(fp_od) : (act == 2) ? int'(n2_od) : int'(n1_od);
    end

    always @(negedge clk) begin
        if (mv && rdy) begin
            chk("sb_pending", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                b = q.pop_front();
                chk("sb_sel", ms, b.sel);
                chk("sb_data", md, b.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vin = 4'hF;
        rdy = 1'b1;
        vd  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        nxt();
        @(negedge clk);
        chk("rst_ready_rr", int'(rr_ir), 0);
        chk("rst_ready_fp", int'(fp_ir), 0);
        chk("rst_ready_n2", int'(n2_ir), 0);
        chk("rst_ready_n1", int'(n1_ir), 0);
        chk("rst_valid", int'(rr_ov), 0);
        nxt();
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 8; i++) q.push_back('{sel: i % 4, data: 'hA0 + i % 4});
        @(negedge clk);
        chk("rel_valid", int'(rr_ov), 0);
        chk("rel_sel", int'(rr_os), 0);
        chk("first_grant", int'(rr_ir), 1);
        for (int k = 0; k < 8; k++) begin
            nxt();
            vin = (k == 7) ? 4'h0 : 4'hF;
            @(negedge clk);
            chk("rot_valid", int'(rr_ov), 1);
        end
        nxt();
        @(negedge clk);
        chk("drain_valid", int'(rr_ov), 0);
        chk("drain_data", int'(rr_od), 'hA3);
        chk("rot_sb_empty", q.size(), 0);

        do_reset(1);
        vd = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        for (int k = 0; k < 6; k++) begin
            vin = (k < 4) ? 4'b1010 : 4'b1000;
            q.push_back('{sel: (k < 4) ? 1 : 3, data: (k < 4) ? 'hC1 : 'hC3});
            @(negedge clk);
            chk("fp_grant", int'(fp_ir), (k < 4) ? 2 : 8);
            nxt();
        end
        vin = '0;
        nxt();
        nxt();
        @(negedge clk);
        chk("fp_idle", int'(fp_ov), 0);
        chk("fp_sb_empty", q.size(), 0);

        do_reset(2);
        vd  = {8'h00, 8'h00, 8'h5A, 8'hA5};
        vin = 4'b0001;
        q.push_back('{sel: 0, data: 'hA5});
        @(negedge clk);
        chk("bp_grant0", int'(n2_ir), 1);
        nxt();
        rdy = 1'b0;
        vin = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", int'(n2_ir), 0);
            chk("bp_hold_valid", int'(n2_ov), 1);
            chk("bp_hold_data", int'(n2_od), 'hA5);
            nxt();
        end
        rdy = 1'b1;
        q.push_back('{sel: 1, data: 'h5A});
        @(negedge clk);
        chk("bp_resume", int'(n2_ir), 2);
        nxt();
        vin = 4'b0001;
        q.push_back('{sel: 0, data: 'hA5});
        @(negedge clk);
        chk("bp_nobubble", int'(n2_ov), 1);
        chk("bp_grant0b", int'(n2_ir), 1);
        nxt();
        vin = '0;
        nxt();
        nxt();
        @(negedge clk);
        chk("bp_sb_empty", q.size(), 0);

        do_reset(0);
        vd  = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        vin = 4'b0100;
        q.push_back('{sel: 2, data: 'hE2});
        @(negedge clk);
        chk("sp_grant2", int'(rr_ir), 4);
        nxt();
        vin = '0;
        repeat (5) nxt();
        vin = 4'b1001;
        q.push_back('{sel: 3, data: 'hE3});
        @(negedge clk);
        chk("sp_grant3", int'(rr_ir), 8);
        nxt();
        vin = 4'b0001;
        q.push_back('{sel: 0, data: 'hE0});
        @(negedge clk);
        chk("sp_grant0", int'(rr_ir), 1);
        nxt();
        vin = '0;
        nxt();
        nxt();
        @(negedge clk);
        chk("sp_sb_empty", q.size(), 0);

        do_reset(3);
        vd  = {8'h00, 8'h00, 8'h00, 8'h77};
        vin = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            q.push_back('{sel: 0, data: 'h77});
            @(negedge clk);
            chk("n1_ready", int'(n1_ir), 1);
            nxt();
        end
        vin = '0;
        nxt();
        nxt();
        @(negedge clk);
        chk("n1_idle", int'(n1_ov), 0);
        chk("n1_sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
